// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants, types and the baud lookup for the UART receive controller.
// Baud table entries are bit-time counts at a 100 MHz system clock.
package uart_pkg;

  localparam logic [15:0] DATA_PORT = 16'h0000;
  localparam logic [15:0] STAT_PORT = 16'h0001;
  localparam logic [15:0] CFG_PORT  = 16'h0002;
  localparam logic [15:0] RX_PORT   = 16'h0004;

  localparam int          RX_RD_BIT  = 0;
  localparam logic [15:0] RX_RD_MASK = 16'h0001 << RX_RD_BIT;
  localparam int          FIFO_DEPTH = 4;
  localparam int          CNT_W      = $clog2(FIFO_DEPTH);

  localparam int BAUD_N = 12;
  // 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  localparam logic [19:0] BAUD_TABLE [BAUD_N] = '{
    20'd333333, 20'd83333, 20'd41667, 20'd20833, 20'd10417, 20'd5208,
    20'd2604,   20'd1736,  20'd868,   20'd434,   20'd217,   20'd109
  };

  localparam int ST_NONEMPTY = 7;
  localparam int ST_FULL     = 6;
  localparam int ST_DROP     = 5;
  localparam int ST_OERR     = 4;
  localparam int ST_FERR     = 3;
  localparam int ST_PERR     = 2;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT} rx_state_e;

  typedef struct packed {
    logic       oerr;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  // Selectors above the table clamp to the fastest rate.
  function automatic logic [19:0] baud_k(input logic [3:0] sel);
    logic [3:0] idx;
    idx = (sel > 4'd11) ? 4'd11 : sel;
    return BAUD_TABLE[idx];
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Processor port bus seen by the UART receive controller.
// Strobes are single-cycle qualifiers of port_id; in_port is valid whenever port_id is.
interface uart_rx_ctrl_if;
  logic [15:0] port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        int_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, int_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, int_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Small power-of-two FIFO for received characters with flush.
// count_o wraps to zero when full; full_o tells the two cases apart.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q[AW-1:0];
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the head slot that cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: configuration register, character sequencing FSM,
// 4-entry receive FIFO and processor port decode with character interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  uart_rx_ctrl_if.slave     bus,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              rx_perr,
  input  logic              rx_ferr,
  input  logic              rx_oerr,
  output logic [15:0]       rx_port_id,
  output logic [15:0]       rx_reads,
  output logic [19:0]       k,
  output logic [19:0]       k_div2,
  output logic              eight,
  output logic              pen,
  output logic              ohel,
  output rx_state_e         dbg_state_o
);

  rx_state_e   state_q;
  rx_entry_t   cap_q;
  logic [15:0] rx_reads_q, rx_port_id_q;
  logic        interrupt_q, drop_q;
  logic [19:0] k_q, k_div2_q;
  logic        eight_q, pen_q, ohel_q;

  logic              cfg_wr, flush, cfg_load, data_rd;
  logic              push_req, push_ok, drop_set;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;
  rx_entry_t         head;
  logic [7:0]        status, in_port_d;

  assign cfg_wr   = bus.write_strobe && (bus.port_id == CFG_PORT);
  // A write with the flush bit set is a flush command only; configuration is kept.
  assign flush    = cfg_wr && bus.out_port[0];
  assign cfg_load = cfg_wr && !bus.out_port[0];
  assign data_rd  = bus.read_strobe && (bus.port_id == DATA_PORT);

  assign push_req = (state_q == CAPTURE);
  assign push_ok  = push_req && !flush && (!fifo_full || data_rd);
  assign drop_set = push_req && !flush && fifo_full && !data_rd;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (data_rd),
    .flush_i (flush),
    .wdata_i (cap_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q      <= BAUD_TABLE[11];
      k_div2_q <= BAUD_TABLE[11] >> 1;
      eight_q  <= 1'b1;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
    end else if (cfg_load) begin
      k_q      <= baud_k(bus.out_port[7:4]);
      k_div2_q <= baud_k(bus.out_port[7:4]) >> 1;
      eight_q  <= bus.out_port[3];
      pen_q    <= bus.out_port[2];
      ohel_q   <= bus.out_port[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) drop_q <= 1'b0;
    else if (drop_set)  drop_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      rx_reads_q   <= '0;
      rx_port_id_q <= '0;
      interrupt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rx_rdy) begin
          cap_q   <= '{oerr: rx_oerr, ferr: rx_ferr, perr: rx_perr, data: rx_data};
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rx_reads_q   <= RX_RD_MASK;
          rx_port_id_q <= RX_PORT;
          state_q      <= ACK;
        end
        ACK: begin
          rx_reads_q   <= '0;
          rx_port_id_q <= '0;
          state_q      <= WAIT;
        end
        WAIT: if (!rx_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // A push outranks a coincident acknowledge so no character goes unannounced.
      if (push_ok)          interrupt_q <= 1'b1;
      else if (bus.int_ack) interrupt_q <= 1'b0;
    end
  end

  always_comb begin
    head                 = fifo_empty ? '0 : rx_entry_t'(fifo_rdata);
    status               = '0;
    status[ST_NONEMPTY]  = !fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_DROP]      = drop_q;
    status[ST_OERR]      = head.oerr;
    status[ST_FERR]      = head.ferr;
    status[ST_PERR]      = head.perr;
    status[1:0]          = fifo_count[1:0];
    in_port_d            = 8'h00;
    case (bus.port_id)
      DATA_PORT: in_port_d = head.data;
      STAT_PORT: in_port_d = status;
      default:   in_port_d = 8'h00;
    endcase
  end

  assign bus.in_port   = in_port_d;
  assign bus.interrupt = interrupt_q;
  assign rx_reads      = rx_reads_q;
  assign rx_port_id    = rx_port_id_q;
  assign k             = k_q;
  assign k_div2        = k_div2_q;
  assign eight         = eight_q;
  assign pen           = pen_q;
  assign ohel          = ohel_q;
  assign dbg_state_o   = state_q;

endmodule
